aes_key_loader: RTL and testbench
=================================

// Module: aes_key_loader
// PURPOSE
//  Upstream key-management stage for the AES-128 datapath. Accepts a cipher key via a valid/ready handshake.
//  Waits until the pipeline is drained, then loads the encrypt key into the first-round stage.
//  Iterates the AES-128 key schedule at one round per cycle, broadcasting each round key to the round stages.
//  Finally loads the round-10 key as the decrypt (inverse) initial key.
// PARAMETERS
//  KEY_W       128  key/round-key width; only 128 supported
//  NUM_ROUNDS  10   key-schedule iterations; only 10 supported
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    reset, asynchronous, active-low
//  key_in       in   128  cipher key; [127:96]=w0 ... [31:0]=w3, byte [127:120] is key byte 0
//  key_valid    in   1    key_in valid; transfer when key_valid & key_ready at posedge
//  key_ready    out  1    high only in IDLE
//  pipe_idle    in   1    high when no packet is in flight in the round pipeline
//  key_out      out  128  key bus to the first-round stage; qualified by set_key / set_inv_key
//  set_key      out  1    1-cycle pulse: key_out is the encrypt round-0 key
//  set_inv_key  out  1    1-cycle pulse: key_out is the decrypt round-0 key (= round-10 key)
//  rk_valid     out  1    round-key broadcast valid
//  rk_idx       out  4    round index 1..10 of rk_out
//  rk_out       out  128  round key rk_idx
//  busy         out  1    high in every state except IDLE
//  done         out  1    1-cycle pulse, coincident with set_inv_key
// BEHAVIOUR
//  - Reset: state=IDLE, key register=0, round counter=0. All outputs are 0 except key_ready=1.
//  - Outputs are decoded from registered state/data only; there is no combinational input->output path.
//  - FSM states: IDLE, WAIT_IDLE, LOAD_ENC, EXPAND, LOAD_DEC.
//    IDLE: on key_valid, capture key_in into rk_reg and go to WAIT_IDLE.
//    WAIT_IDLE: stay until pipe_idle is sampled 1 at a posedge, then go to LOAD_ENC.
//    LOAD_ENC (1 cycle): set_key=1, key_out=rk_reg (the original key); rnd<=1; go to EXPAND.
//    EXPAND (10 cycles): each posedge computes rk_reg <= next(rk_reg, rcon[rnd]) and increments rnd.
//      In cycle n of EXPAND: rk_valid=1, rk_idx=n, rk_out = round key n.
//      After rnd=10 is produced, go to LOAD_DEC.
//    LOAD_DEC (1 cycle): set_inv_key=1, done=1, key_out=round-10 key; go to IDLE.
//  - Key schedule: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//    rcon sequence: 01 02 04 08 10 20 40 80 1b 36.
//  - Latency with pipe_idle=1: handshake at edge E0 -> WAIT_IDLE during cycle 1 -> set_key in cycle 2
//    -> rk_idx 1..10 in cycles 3-12 -> set_inv_key and done in cycle 13.
//  - key_out holds its last value when neither set_* is asserted. Consumers must use it only under set_*.
//  - key_valid outside IDLE is ignored (key_ready=0). A new key is accepted in the first IDLE cycle after done.
//  - pipe_idle is ignored outside WAIT_IDLE. Dropping pipe_idle during EXPAND has no effect.
//  - Async reset mid-operation returns to IDLE immediately. No partial set_key or set_inv_key pulse is issued after reset.
//  - set_key, rk_valid and set_inv_key are mutually exclusive; each is asserted exactly once per accepted key.
// STRUCTURE
//  - sysdef.svh holds AES_ROUNDS=10, the rcon table (10 x 8 bit), the key_fsm_t enum, and KEY_W.
//  - Sub-module aes_sbox: combinational forward S-box, 8-bit in/out. 4 instances implement SubWord.
//  - One always_ff block for the state, rk_reg and rnd registers. Next-key logic is combinational.
// TESTING
//  1. Reset with key_valid=1 -> all outputs 0 except key_ready=1; no capture while rst_n=0.
//  2. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pipe_idle=1:
//     -> set_key in cycle 2 with that key.
//     -> rk_idx=1 with rk_out=a0fafe1788542cb123a339392a6c7605.
//     -> set_inv_key and done in cycle 13 with key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  3. pipe_idle=0 for 5 cycles after the handshake -> remains in WAIT_IDLE, busy=1, set_key=0.
//     -> set_key occurs in the cycle after pipe_idle is sampled 1.
//  4. key_valid pulsed in cycles 5 and 12 during a load -> ignored; rk_out sequence and final key unchanged.
//     -> key_ready=1 in the cycle after done.
//  5. rst_n asserted during EXPAND at rk_idx=4 -> IDLE immediately; no set_inv_key.
//     -> a reload of the all-zero key gives round-10 key b4ef5bcb3e92e21123e951cf6f8f188e.
//  6. Back-to-back keys: key_valid held high with a new key -> second key accepted in the first IDLE cycle.
//     -> exactly one set_key, 10 rk_valid and one set_inv_key per key.

Source files
------------

// File: rtl/aes_key_loader_pkg.sv
// Shared definitions for the AES-128 key loader.
//   AES_KEY_W  : key / round-key width (128 only)
//   AES_ROUNDS : number of key-schedule iterations (10 only)
//   key_fsm_t  : loader state encoding
//   rcon()     : round-constant table, index 0 -> round 1
package aes_key_loader_pkg;

    localparam int AES_KEY_W  = 128;
    localparam int AES_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_LOAD_ENC,
        ST_EXPAND,
        ST_LOAD_DEC
    } key_fsm_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_loader_sbox.sv
// Forward AES S-box, purely combinational.
//   i_byte : input byte
//   o_byte : SubBytes(i_byte)
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Byte 0 of the table is the most significant byte of the literal,
    // so entry i lives at bit offset 8*(255-i) = 8*~i.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_ofs;

    assign w_ofs  = {~i_byte, 3'b000};
    assign o_byte = SBOX_TABLE[w_ofs +: 8];

endmodule

// File: rtl/aes_key_loader.sv
// AES-128 key loader: accepts a cipher key, waits for the round pipeline
// to drain, loads the encrypt key, broadcasts round keys 1..10 one per
// cycle, then loads the round-10 key as the decrypt initial key.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_in       : cipher key (w0 in [127:96])
//   key_valid    : key_in valid, accepted when key_ready
//   key_ready    : high only in IDLE
//   pipe_idle    : round pipeline empty (sampled in WAIT_IDLE only)
//   key_out      : key bus, qualified by set_key / set_inv_key
//   set_key      : pulse, key_out is the encrypt round-0 key
//   set_inv_key  : pulse, key_out is the round-10 key
//   rk_valid     : round-key broadcast valid
//   rk_idx       : round index 1..10
//   rk_out       : round key rk_idx
//   busy         : high outside IDLE
//   done         : pulse coincident with set_inv_key
module aes_key_loader
    import aes_key_loader_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_ROUNDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             pipe_idle,
    output logic [KEY_W-1:0] key_out,
    output logic             set_key,
    output logic             set_inv_key,
    output logic             rk_valid,
    output logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             busy,
    output logic             done
);

    key_fsm_t         r_state;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] r_key_out;
    logic [3:0]       r_rnd;
    logic             r_set_key;
    logic             r_set_inv;
    logic             r_rk_valid;
    logic             r_busy;
    logic             r_key_ready;

    logic [31:0]      w_w0, w_w1, w_w2, w_w3;
    logic [31:0]      w_rot, w_sub, w_t;
    logic [31:0]      w_n0, w_n1, w_n2, w_n3;
    logic [7:0]       w_rcon;
    logic [KEY_W-1:0] w_next;

    // Round 1 is computed on the LOAD_ENC edge, so rk_reg already holds
    // round key n while EXPAND presents rk_idx = n.
    assign w_rcon = rcon((r_state == ST_LOAD_ENC) ? 4'd0 : r_rnd);

    assign w_w0  = r_key[127:96];
    assign w_w1  = r_key[95:64];
    assign w_w2  = r_key[63:32];
    assign w_w3  = r_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t    = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0   = w_w0 ^ w_t;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_key_out   <= '0;
            r_rnd       <= '0;
            r_set_key   <= 1'b0;
            r_set_inv   <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        r_key       <= key_in;
                        r_busy      <= 1'b1;
                        r_key_ready <= 1'b0;
                        r_state     <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (pipe_idle) begin
                        r_key_out <= r_key;
                        r_set_key <= 1'b1;
                        r_state   <= ST_LOAD_ENC;
                    end
                end
                ST_LOAD_ENC: begin
                    r_set_key  <= 1'b0;
                    r_key      <= w_next;
                    r_rnd      <= 4'd1;
                    r_rk_valid <= 1'b1;
                    r_state    <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    if (r_rnd == 4'(NUM_ROUNDS)) begin
                        r_rk_valid <= 1'b0;
                        r_key_out  <= r_key;
                        r_set_inv  <= 1'b1;
                        r_state    <= ST_LOAD_DEC;
                    end else begin
                        r_key <= w_next;
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                ST_LOAD_DEC: begin
                    r_set_inv   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_key_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_ready   = r_key_ready;
    assign key_out     = r_key_out;
    assign set_key     = r_set_key;
    assign set_inv_key = r_set_inv;
    assign done        = r_set_inv;
    assign rk_valid    = r_rk_valid;
    assign rk_idx      = r_rnd;
    assign rk_out      = r_key;
    assign busy        = r_busy;

endmodule

// File: tb/tb_aes_key_loader.sv
module tb_aes_key_loader;

    localparam int K_SET = 0;
    localparam int K_RK  = 1;
    localparam int K_INV = 2;

    typedef struct {
        int           kind;
        int           idx;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         pipe_idle;
    logic [127:0] key_out;
    logic         set_key;
    logic         set_inv_key;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt_set = 0;
    int cnt_rk  = 0;
    int cnt_inv = 0;

    exp_t q[$];

    logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] KEY_ZERO = 128'h0;

    logic [127:0] fips_rk [10] = '{
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] zero_rk [10] = '{
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    aes_key_loader #(.KEY_W(128), .NUM_ROUNDS(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .pipe_idle   (pipe_idle),
        .key_out     (key_out),
        .set_key     (set_key),
        .set_inv_key (set_inv_key),
        .rk_valid    (rk_valid),
        .rk_idx      (rk_idx),
        .rk_out      (rk_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_key(input bit use_zero);
        exp_t e;
        e.kind = K_SET;
        e.idx  = 0;
        e.data = use_zero ? KEY_ZERO : KEY_FIPS;
        q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            e.kind = K_RK;
            e.idx  = i + 1;
            e.data = use_zero ? zero_rk[i] : fips_rk[i];
            q.push_back(e);
        end
        e.kind = K_INV;
        e.idx  = 0;
        e.data = use_zero ? zero_rk[9] : fips_rk[9];
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drain", 128'(q.size()), 128'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), 128'd1);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_set_key"}, 128'(set_key), 128'd0);
        chk({tag, "_set_inv"}, 128'(set_inv_key), 128'd0);
        chk({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_rk_idx"}, 128'(rk_idx), 128'd0);
        chk({tag, "_key_out"}, key_out, 128'd0);
        chk({tag, "_rk_out"}, rk_out, 128'd0);
    endtask

    // Monitor: pops the next expected event whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((int'(set_key) + int'(rk_valid) + int'(set_inv_key)) > 1)
                chk("exclusive_outputs", {125'd0, set_key, rk_valid, set_inv_key}, 128'd0);
            if (set_key || rk_valid || set_inv_key) begin
                if (set_key) cnt_set++;
                if (rk_valid) cnt_rk++;
                if (set_inv_key) cnt_inv++;
                chk("done_with_inv", 128'(done), 128'(set_inv_key));
                if (q.size() == 0) begin
                    chk("unexpected_output", {125'd0, set_key, rk_valid, set_inv_key}, 128'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.kind == K_SET) begin
                        chk("set_key_event", 128'(set_key), 128'd1);
                        chk("set_key_data", key_out, e.data);
                    end else if (e.kind == K_RK) begin
                        chk("rk_event", 128'(rk_valid), 128'd1);
                        chk("rk_idx", 128'(rk_idx), 128'(e.idx));
                        chk("rk_data", rk_out, e.data);
                    end else begin
                        chk("set_inv_event", 128'(set_inv_key), 128'd1);
                        chk("set_inv_data", key_out, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_set, s_rk, s_inv;
        bit found;

        // Test 1: reset with key_valid high
        rst_n     = 1'b0;
        key_valid = 1'b1;
        key_in    = KEY_FIPS;
        pipe_idle = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        key_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("post_reset_no_capture_busy", 128'(busy), 128'd0);
        chk("post_reset_key_ready", 128'(key_ready), 128'd1);

        // Test 2: FIPS-197 key, latency
        key_in    = KEY_FIPS;
        key_valid = 1'b1;
        push_key(1'b0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("t2_busy_c1", 128'(busy), 128'd1);
        chk("t2_key_ready_c1", 128'(key_ready), 128'd0);
        @(posedge clk); #1;
        chk("t2_set_key_c2", 128'(set_key), 128'd1);
        @(posedge clk); #1;
        chk("t2_rk_idx_c3", 128'(rk_idx), 128'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_done_c13", 128'(done), 128'd1);
        chk("t2_inv_key_c13", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain();

        // Test 3: pipe_idle held low for 5 cycles
        pipe_idle = 1'b0;
        key_in    = KEY_ZERO;
        key_valid = 1'b1;
        push_key(1'b1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_wait_busy", 128'(busy), 128'd1);
            chk("t3_wait_no_set_key", 128'(set_key), 128'd0);
        end
        @(negedge clk);
        pipe_idle = 1'b1;
        @(posedge clk); #1;
        chk("t3_set_key_after_idle", 128'(set_key), 128'd1);
        drain();

        // Test 4: key_valid pulses during a load are ignored
        @(negedge clk);
        key_in    = KEY_FIPS;
        key_valid = 1'b1;
        push_key(1'b0);
        @(posedge clk); #1;
        for (int c = 1; c <= 13; c++) begin
            key_valid = (c == 5 || c == 12);
            key_in    = (c == 5 || c == 12) ? KEY_ZERO : KEY_FIPS;
            if (c == 13) chk("t4_done_c13", 128'(done), 128'd1);
            @(posedge clk); #1;
        end
        chk("t4_key_ready_after_done", 128'(key_ready), 128'd1);
        drain();

        // Test 5: reset during EXPAND at rk_idx=4
        @(negedge clk);
        key_in    = KEY_FIPS;
        key_valid = 1'b1;
        push_key(1'b0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rk_valid && rk_idx == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t5_reached_rk4", 128'(found), 128'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_async_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_idle_after_reset", 128'(busy), 128'd0);
        key_in    = KEY_ZERO;
        key_valid = 1'b1;
        push_key(1'b1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        drain();

        // Test 6: back-to-back keys with key_valid held
        s_set = cnt_set;
        s_rk  = cnt_rk;
        s_inv = cnt_inv;
        @(negedge clk);
        key_in    = KEY_FIPS;
        key_valid = 1'b1;
        push_key(1'b0);
        push_key(1'b1);
        @(posedge clk); #1;
        key_in = KEY_ZERO;
        repeat (13) @(posedge clk);
        #1;
        chk("t6_key_ready_c14", 128'(key_ready), 128'd1);
        @(posedge clk); #1;
        chk("t6_second_accepted", 128'(busy), 128'd1);
        key_valid = 1'b0;
        drain();
        chk("t6_set_key_count", 128'(cnt_set - s_set), 128'd2);
        chk("t6_rk_valid_count", 128'(cnt_rk - s_rk), 128'd20);
        chk("t6_set_inv_count", 128'(cnt_inv - s_inv), 128'd2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
